bp_update_ctrl: RTL

Controller that owns the single write port of the branch predictor table (BTB/BHT) and sequences every write to it. It sits between the EX stage and the predictor. It does three things: it runs a clear sweep after reset and on invalidate request, it queues EX-stage branch outcomes in a 2-entry FIFO while the port is busy, and it produces the misprediction redirect for the IF stage. While a sweep is in progress it gates predictor lookups off so the IF stage falls back to PC+4.

---
 rtl/bp_update_ctrl_if.sv | 24 ++
 rtl/bp_update_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/bp_update_ctrl_if.sv
// EX-stage branch update bus between the pipeline and bp_update_ctrl.
// master: EX stage (drives the resolved branch, receives stall and redirect).
// slave:  bp_update_ctrl.
interface bp_update_ctrl_if;
  logic        br_valid_e;
  logic [31:0] br_pc_e;
  logic [31:0] br_target_e;
  logic        br_taken_e;
  logic        br_pred_taken_e;
  logic [31:0] br_pred_target_e;
  logic        stall_e;
  logic        redirect;
  logic [31:0] redirect_pc;

  modport master (
    output br_valid_e, br_pc_e, br_target_e, br_taken_e, br_pred_taken_e, br_pred_target_e,
    input  stall_e, redirect, redirect_pc
  );

  modport slave (
    input  br_valid_e, br_pc_e, br_target_e, br_taken_e, br_pred_taken_e, br_pred_target_e,
    output stall_e, redirect, redirect_pc
  );
endinterface

// File: rtl/bp_update_ctrl.sv
// Branch predictor table write-port controller.
// Sweeps the table clear after reset / on invalidate, queues EX updates in a
// 2-entry FIFO while the port is busy, and generates the misprediction redirect.
// Optional build macro: BP_STATS_EN adds the branch / mispredict counters.
module bp_update_ctrl #(
  parameter int unsigned IDX_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  bp_update_ctrl_if.slave   ex,
  input  logic              inv_req,
  output logic              inv_ack,
  output logic              pred_en,
  output logic              busy,
  output logic              tbl_we,
  output logic [IDX_W-1:0]  tbl_idx,
  output logic              tbl_clear,
  output logic [31:0]       tbl_tag,
  output logic [31:0]       tbl_target,
  output logic              tbl_taken,
  output logic [31:0]       stat_branches,
  output logic [31:0]       stat_mispredicts
);

  typedef enum logic [0:0] {StSweep, StIdle} state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic        taken;
  } upd_t;

  // Counter carries one extra bit: value 2^IDX_W is the tail cycle in which the
  // last clear is on the port and nothing new is issued.
  localparam logic [IDX_W:0] SweepEnd = {1'b1, {IDX_W{1'b0}}};
  localparam logic [IDX_W:0] CntOne   = {{IDX_W{1'b0}}, 1'b1};

  state_e         state_q, state_d;
  logic [IDX_W:0] cnt_q, cnt_d;

  logic [1:0]     fcnt_q, fcnt_d;
  upd_t           ent0_q, ent0_d;
  upd_t           ent1_q, ent1_d;
  upd_t           in_upd;

  logic           wr_en, wr_clear;
  logic [IDX_W-1:0] wr_idx;
  upd_t           wr_upd;

  logic           tbl_we_q, tbl_clear_q, tbl_taken_q;
  logic [IDX_W-1:0] tbl_idx_q;
  logic [31:0]    tbl_tag_q, tbl_target_q;
  logic           inv_ack_q;

  logic           fifo_full;
  logic           stall;
  logic           accepted;
  logic           redirect_w;
  logic           inv_accept;

  assign in_upd    = {ex.br_pc_e, ex.br_target_e, ex.br_taken_e};
  assign fifo_full = (fcnt_q == 2'd2);

  // Only a sweep can fill the FIFO; in IDLE each cycle pops, so no stall there.
  assign stall      = ex.br_valid_e & fifo_full & (state_q == StSweep);
  assign accepted   = ex.br_valid_e & ~stall;
  assign redirect_w = accepted &
                      ((ex.br_taken_e != ex.br_pred_taken_e) |
                       (ex.br_taken_e & (ex.br_target_e != ex.br_pred_target_e)));

  assign ex.stall_e     = stall;
  assign ex.redirect    = redirect_w;
  assign ex.redirect_pc = ex.br_taken_e ? ex.br_target_e : ex.br_pc_e + 32'd4;

  // Requester holds inv_req through the ack cycle, so ignore it while acking.
  assign inv_accept = (state_q == StIdle) & inv_req & ~inv_ack_q;

  assign busy    = (state_q == StSweep);
  assign pred_en = (state_q == StIdle);
  assign inv_ack = inv_ack_q;

  assign tbl_we     = tbl_we_q;
  assign tbl_idx    = tbl_idx_q;
  assign tbl_clear  = tbl_clear_q;
  assign tbl_tag    = tbl_tag_q;
  assign tbl_target = tbl_target_q;
  assign tbl_taken  = tbl_taken_q;

  // FSM state and sweep counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StSweep;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next state: sweep runs to the tail cycle, invalidate restarts it at 0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StSweep: begin
        if (cnt_q == SweepEnd) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StIdle: begin
        if (inv_accept) begin
          state_d = StSweep;
          cnt_d   = '0;
        end
      end
      default: state_d = StSweep;
    endcase
  end

  // FSM outputs: pick this cycle's table write and the FIFO next state.
  always_comb begin
    wr_en    = 1'b0;
    wr_clear = 1'b0;
    wr_idx   = '0;
    wr_upd   = '0;
    fcnt_d   = fcnt_q;
    ent0_d   = ent0_q;
    ent1_d   = ent1_q;
    unique case (state_q)
      StSweep: begin
        if (!cnt_q[IDX_W]) begin
          wr_en    = 1'b1;
          wr_clear = 1'b1;
          wr_idx   = cnt_q[IDX_W-1:0];
        end
        if (ex.br_valid_e && !fifo_full) begin
          if (fcnt_q == 2'd0) begin
            ent0_d = in_upd;
          end else begin
            ent1_d = in_upd;
          end
          fcnt_d = fcnt_q + 2'd1;
        end
      end
      StIdle: begin
        if (inv_accept) begin
          // Invalidate supersedes queued and in-flight updates.
          fcnt_d = 2'd0;
        end else if (fcnt_q == 2'd0) begin
          if (ex.br_valid_e) begin
            wr_en  = 1'b1;
            wr_upd = in_upd;
            wr_idx = in_upd.pc[IDX_W+1:2];
          end
        end else begin
          wr_en  = 1'b1;
          wr_upd = ent0_q;
          wr_idx = ent0_q.pc[IDX_W+1:2];
          if (fcnt_q == 2'd2) begin
            ent0_d = ent1_q;
            if (ex.br_valid_e) begin
              ent1_d = in_upd;
            end else begin
              fcnt_d = 2'd1;
            end
          end else begin
            if (ex.br_valid_e) begin
              ent0_d = in_upd;
            end else begin
              fcnt_d = 2'd0;
            end
          end
        end
      end
      default: ;
    endcase
  end

  // FIFO storage, registered table write port and invalidate ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_q       <= 2'd0;
      ent0_q       <= '0;
      ent1_q       <= '0;
      tbl_we_q     <= 1'b0;
      tbl_clear_q  <= 1'b0;
      tbl_idx_q    <= '0;
      tbl_tag_q    <= '0;
      tbl_target_q <= '0;
      tbl_taken_q  <= 1'b0;
      inv_ack_q    <= 1'b0;
    end else begin
      fcnt_q       <= fcnt_d;
      ent0_q       <= ent0_d;
      ent1_q       <= ent1_d;
      tbl_we_q     <= wr_en;
      tbl_clear_q  <= wr_clear;
      tbl_idx_q    <= wr_idx;
      tbl_tag_q    <= wr_upd.pc;
      tbl_target_q <= wr_upd.target;
      tbl_taken_q  <= wr_upd.taken;
      inv_ack_q    <= (state_q == StSweep) && (cnt_q == SweepEnd) && inv_req;
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] stat_br_q;
  logic [31:0] stat_mp_q;

  // Accepted-branch and redirect counters, wrapping at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      if (accepted) begin
        stat_br_q <= stat_br_q + 32'd1;
      end
      if (redirect_w) begin
        stat_mp_q <= stat_mp_q + 32'd1;
      end
    end
  end

  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mp_q;
`else
  assign stat_branches    = '0;
  assign stat_mispredicts = '0;
`endif

endmodule
